// File: rtl/mux_pkg.sv
// Shared types and helpers for the muxn M-way handshake steering multiplexer.
package mux_pkg;

    localparam int MAX_M = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RTZ  = 2'd2
    } mux_state_t;

    // True when exactly one bit of the (zero-extended) vector is set.
    function automatic bit onehot_valid(input logic [MAX_M-1:0] vec);
        return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/muxn_onehot_enc.sv
// One-hot encoder: flags an exactly-one-hot vector and returns the index of its set bit.
module onehot_enc
    import mux_pkg::*;
#(
    parameter  int M  = 2,
    localparam int SW = $clog2(M)
) (
    input  logic [M-1:0]  vec_i,
    output logic          valid_o,
    output logic [SW-1:0] idx_o
);

    assign valid_o = onehot_valid(MAX_M'(vec_i));

    // OR of the indices of set bits; meaningful only when valid_o is high.
    always_comb begin
        idx_o = '0;
        for (int k = 0; k < M; k++) begin
            if (vec_i[k]) begin
                idx_o = idx_o | SW'(k);
            end
        end
    end

endmodule

// File: rtl/muxn.sv
// M-way four-phase handshake steering mux with registered outputs.
// Optional sticky control-error monitor (err_o) enabled by defining MUX_CHECK_EN.
module muxn
    import mux_pkg::*;
#(
    parameter  int N  = 32,
    parameter  int M  = 2,
    localparam int SW = $clog2(M)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [M-1:0]   r_i,
    output logic [M-1:0]   a_i,
    input  logic [M*N-1:0] d_i,
    input  logic [M-1:0]   ctl_i,
    output logic           actl_o,
    output logic           r_o,
    input  logic           a_o,
    output logic [N-1:0]   d_o,
`ifdef MUX_CHECK_EN
    output logic           err_o,
`endif
    output mux_state_t     dbg_state_o
);

    mux_state_t    state_q;
    logic          r_o_q;
    logic [M-1:0]  a_i_q;
    logic          actl_q;
    logic [N-1:0]  d_q;
    logic [SW-1:0] sel_q;

    logic          enc_valid;
    logic [SW-1:0] enc_idx;
    logic          capture;

    onehot_enc #(.M(M)) u_enc (
        .vec_i   (ctl_i),
        .valid_o (enc_valid),
        .idx_o   (enc_idx)
    );

    assign capture = (state_q == IDLE) && enc_valid && r_i[enc_idx];

    // Handshake: the selected producer's request is captured in IDLE; r_o is held
    // until a_o rises, then a_i[sel_q]/actl_o are held until a_o, r_i[sel_q] and
    // ctl_i have all returned to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            r_o_q   <= 1'b0;
            a_i_q   <= '0;
            actl_q  <= 1'b0;
            d_q     <= '0;
            sel_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        d_q     <= d_i[enc_idx*N +: N];
                        sel_q   <= enc_idx;
                        r_o_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (a_o) begin
                        r_o_q   <= 1'b0;
                        a_i_q   <= M'(1) << sel_q;
                        actl_q  <= 1'b1;
                        state_q <= RTZ;
                    end
                end
                RTZ: begin
                    if (!a_o && !r_i[sel_q] && (ctl_i == '0)) begin
                        a_i_q   <= '0;
                        actl_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    r_o_q   <= 1'b0;
                    a_i_q   <= '0;
                    actl_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign r_o         = r_o_q;
    assign a_i         = a_i_q;
    assign actl_o      = actl_q;
    assign d_o         = d_q;
    assign dbg_state_o = state_q;

`ifdef MUX_CHECK_EN
    logic         err_q;
    logic [M-1:0] ctl_q;

    // Multi-hot control while idle, or any control change while the output is requested.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
            ctl_q <= '0;
        end else begin
            if (capture) begin
                ctl_q <= ctl_i;
            end
            if (((state_q == IDLE) && (ctl_i != '0) && !enc_valid) ||
                ((state_q == REQ) && (ctl_i != ctl_q))) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_muxn.sv
// Self-checking bench for muxn (N=8, M=4): vector table, directed corner sequences,
// and randomized transfers checked against a transaction-level expectation queue.
module tb_muxn;
    import mux_pkg::*;

    localparam int N = 8;
    localparam int M = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [M-1:0]   r_i;
    logic [M-1:0]   a_i;
    logic [M*N-1:0] d_i;
    logic [M-1:0]   ctl_i;
    logic           actl_o;
    logic           r_o;
    logic           a_o;
    logic [N-1:0]   d_o;
`ifdef MUX_CHECK_EN
    logic           err_o;
`endif
    mux_state_t     dbg_state;

    muxn #(.N(N), .M(M)) dut (
        .clk         (clk),
        .rst         (rst),
        .r_i         (r_i),
        .a_i         (a_i),
        .d_i         (d_i),
        .ctl_i       (ctl_i),
        .actl_o      (actl_o),
        .r_o         (r_o),
        .a_o         (a_o),
        .d_o         (d_o),
`ifdef MUX_CHECK_EN
        .err_o       (err_o),
`endif
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [M-1:0] allowed = '0;
    logic [N-1:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acknowledge may only ever go to the channel the bench selected, never alongside r_o.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("ack_only_sel", 64'(a_i & ~allowed), 64'(0));
            check("req_ack_excl", 64'(r_o & (|a_i)), 64'(0));
        end
    end

    // ---------------- driver ----------------
    // One complete transfer on channel s. Returns the cycle at which r_o rose.
    task automatic do_xfer(input int s, input logic [N-1:0] data, input logic [M-1:0] extra_r,
                           input bit rnd, output int rise_cyc);
        int ord[3];
        int tmp;
        int j2;
        logic [N-1:0] exp_d;
        logic [M-1:0] sel_mask;
        sel_mask = M'(1) << s;
        allowed  = sel_mask;
        d_i      = $urandom;
        d_i[s*N +: N] = data;
        ctl_i    = sel_mask;
        r_i      = sel_mask | extra_r;
        exp_q.push_back(data);
        tick();
        rise_cyc = cyc;
        exp_d = exp_q.pop_front();
        check("req_latency", 64'(r_o), 64'(1));
        check("d_o_capture", 64'(d_o), 64'(exp_d));
        if (rnd) begin
            repeat ($urandom_range(0, 3)) begin
                d_i = $urandom;
                tick();
                check("req_hold_r", 64'(r_o), 64'(1));
                check("req_hold_d", 64'(d_o), 64'(exp_d));
            end
        end
        a_o = 1'b1;
        tick();
        check("ack_r_o_low", 64'(r_o), 64'(0));
        check("ack_a_i", 64'(a_i), 64'(sel_mask));
        check("ack_actl", 64'(actl_o), 64'(1));
        ord = '{0, 1, 2};
        if (rnd) begin
            for (int j = 2; j > 0; j--) begin
                j2 = $urandom_range(0, j);
                tmp = ord[j]; ord[j] = ord[j2]; ord[j2] = tmp;
            end
        end
        for (int j = 0; j < 3; j++) begin
            case (ord[j])
                0: a_o = 1'b0;
                1: r_i[s] = 1'b0;
                default: ctl_i = '0;
            endcase
            if (!rnd && j < 2) continue;
            tick();
            if (j < 2) begin
                check("rtz_wait_a_i", 64'(a_i), 64'(sel_mask));
                check("rtz_wait_actl", 64'(actl_o), 64'(1));
            end else begin
                check("rtz_done_a_i", 64'(a_i), 64'(0));
                check("rtz_done_actl", 64'(actl_o), 64'(0));
                check("rtz_done_r_o", 64'(r_o), 64'(0));
                check("d_o_kept", 64'(d_o), 64'(exp_d));
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [M-1:0]   ctl;
        logic [M-1:0]   r;
        logic [M*N-1:0] d;
        bit             cap;
        logic [N-1:0]   exp_d;
    } vec_t;

    vec_t vt[7];

    initial begin
        int rc;
        int prev_rc;
        logic [N-1:0] held;

        vt[0] = '{4'b0100, 4'b0100, 32'h113C2233, 1'b1, 8'h3C};
        vt[1] = '{4'b0010, 4'b1011, 32'h44556677, 1'b1, 8'h66};
        vt[2] = '{4'b0110, 4'b0110, 32'h01020304, 1'b0, 8'h66};
        vt[3] = '{4'b0000, 4'b1111, 32'hAABBCCDD, 1'b0, 8'h66};
        vt[4] = '{4'b0001, 4'b1110, 32'h99887766, 1'b0, 8'h66};
        vt[5] = '{4'b1000, 4'b1000, 32'h9A000000, 1'b1, 8'h9A};
        vt[6] = '{4'b0001, 4'b0001, 32'h000000E1, 1'b1, 8'hE1};

        rst = 1'b0; r_i = '0; ctl_i = '0; d_i = '0; a_o = 1'b0;
        tick(); tick();
        check("rst_r_o", 64'(r_o), 64'(0));
        check("rst_a_i", 64'(a_i), 64'(0));
        check("rst_actl", 64'(actl_o), 64'(0));
        check("rst_d_o", 64'(d_o), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(IDLE));
`ifdef MUX_CHECK_EN
        check("rst_err", 64'(err_o), 64'(0));
`endif
        rst = 1'b1;
        tick();

        // Invalid multi-hot control: never captures.
        ctl_i = 4'b0110; r_i = 4'b0110; d_i = 32'h00112200;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("inval_r_o", 64'(r_o), 64'(0));
`ifdef MUX_CHECK_EN
            check("inval_err", 64'(err_o), 64'(1));
`endif
        end
        ctl_i = 4'b0000; r_i = '0;
        tick();
`ifdef MUX_CHECK_EN
        check("err_sticky", 64'(err_o), 64'(1));
`endif

        // Reset in the middle of a transfer, then recapture.
        allowed = 4'b0100;
        ctl_i = 4'b0100; r_i = 4'b0100; d_i = 32'h00A50000;
        tick();
        check("mid_req", 64'(r_o), 64'(1));
        tick();
        #2 rst = 1'b0;
        #1;
        check("mid_rst_r_o", 64'(r_o), 64'(0));
        check("mid_rst_d_o", 64'(d_o), 64'(0));
        check("mid_rst_a_i", 64'(a_i), 64'(0));
        check("mid_rst_actl", 64'(actl_o), 64'(0));
`ifdef MUX_CHECK_EN
        check("mid_rst_err", 64'(err_o), 64'(0));
`endif
        tick();
        rst = 1'b1;
        check("post_rst_state", 64'(dbg_state), 64'(IDLE));
        tick();
        check("recap_r_o", 64'(r_o), 64'(1));
        check("recap_d_o", 64'(d_o), 64'(8'hA5));
        a_o = 1'b1; tick();
        a_o = 1'b0; r_i = '0; ctl_i = '0; tick();
        check("recap_done", 64'(a_i), 64'(0));

        // Table-driven single-step vectors.
        for (int i = 0; i < 7; i++) begin
            allowed = vt[i].cap ? vt[i].ctl : '0;
            ctl_i = vt[i].ctl; r_i = vt[i].r; d_i = vt[i].d;
            tick();
            check($sformatf("vec%0d_r_o", i), 64'(r_o), 64'(vt[i].cap));
            check($sformatf("vec%0d_d_o", i), 64'(d_o), 64'(vt[i].exp_d));
            if (vt[i].cap) begin
                a_o = 1'b1;
                tick();
                check($sformatf("vec%0d_a_i", i), 64'(a_i), 64'(vt[i].ctl));
                check($sformatf("vec%0d_actl", i), 64'(actl_o), 64'(1));
                a_o = 1'b0; r_i = '0; ctl_i = '0;
                tick();
                check($sformatf("vec%0d_rtz", i), 64'({a_i, actl_o}), 64'(0));
            end else begin
                ctl_i = '0; r_i = '0;
                tick();
            end
        end

        // Back-to-back with a zero-delay consumer, alternating channels 0 and 3.
        prev_rc = 0;
        for (int i = 0; i < 16; i++) begin
            do_xfer((i % 2 == 1) ? 3 : 0, N'($urandom), '0, 1'b0, rc);
            if (i > 0) check("b2b_period", 64'(rc - prev_rc), 64'(3));
            prev_rc = rc;
        end

        // Stall in REQ while control and data wander.
        allowed = 4'b1000;
        ctl_i = 4'b1000; r_i = 4'b1000; d_i = 32'h5A000000;
        tick();
        held = 8'h5A;
        check("stall_req", 64'(r_o), 64'(1));
        for (int i = 0; i < 20; i++) begin
            d_i = $urandom;
            ctl_i = M'($urandom);
            tick();
            check("stall_d_o", 64'(d_o), 64'(held));
            check("stall_a_i", 64'(a_i), 64'(0));
            check("stall_r_o", 64'(r_o), 64'(1));
        end
        a_o = 1'b1; tick();
        check("stall_ack", 64'(a_i), 64'(4'b1000));
        a_o = 1'b0; r_i = '0; ctl_i = '0; tick();
        check("stall_rtz", 64'(a_i), 64'(0));

        // Randomized transfers with waiting requests on other channels.
        for (int i = 0; i < 40; i++) begin
            int s;
            s = $urandom_range(0, M - 1);
            do_xfer(s, N'($urandom), M'($urandom), 1'b1, rc);
            r_i = '0;
            repeat ($urandom_range(0, 2)) tick();
        end

        check("exp_q_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/muxn.md
# muxn

Clocked, parametrised M-way steering multiplexer using four-phase request/acknowledge handshakes. Generalises the two-input, dual-rail-controlled handshake mux to M data channels. A one-hot control channel picks which input transfer is forwarded to the single output channel. It sits between producer stages and a shared consumer, adds registered outputs, and has an optional control-error monitor.

## Interface
- N, default 32, data width in bits (≥1)
- M, default 2, number of input channels (≥2); SW = $clog2(M) is derived and not overridable
- clk  in  1  clock; all other inputs are synchronous to clk
- rst  in  1  reset, asynchronous and active-low (rst=0 → reset)
- r_i  in  M  per-channel request
- a_i  out  M  per-channel acknowledge
- d_i  in  M×N  packed input data; channel k occupies d_i[k*N +: N]
- ctl_i  in  M  one-hot control rails; all-zero is the spacer
- actl_o  out  1  control acknowledge
- r_o  out  1  output request
- a_o  in  1  output acknowledge
- d_o  out  N  output data
- err_o  out  1  sticky control error; present only with MUX_CHECK_EN

## Operation
- The FSM has three states: IDLE, REQ and RTZ. All outputs are registered.
- IDLE: r_o=0, a_i=0, actl_o=0. If ctl_i is exactly one-hot (index s) and r_i[s]=1, capture d_i[s] into d_o, capture s into sel_q, then go to REQ.
- REQ: r_o=1 and d_o is held stable. When a_o=1, go to RTZ.
- RTZ: r_o=0, a_i[sel_q]=1, actl_o=1. When a_o=0, r_i[sel_q]=0 and ctl_i=0 are all true in the same cycle, go to IDLE. a_i and actl_o drop on entry to IDLE.
- Only channel sel_q is ever acknowledged. The a_i bits of all other channels stay 0.
- Requests on non-selected channels are ignored. They wait and are not lost.
- ctl_i with more than one bit set counts as not valid: the FSM stays in IDLE.
- Changes on ctl_i or d_i after capture are ignored until the FSM returns to IDLE.
- d_o keeps the last captured value in IDLE. It is not cleared.

## Timing
- Reset values: state=IDLE, r_o=0, a_i=0, actl_o=0, d_o=0, sel_q=0, err_o=0.
- Reset takes effect asynchronously, including in the middle of a transfer. Any partial transfer is abandoned and is not resumed.
- Latency: a capture condition sampled at edge t gives r_o=1 after edge t.
- a_o=1 sampled at edge t gives r_o=0 and a_i[sel_q]=1 after edge t.
- The return-to-zero condition sampled at edge t gives a_i=0 and actl_o=0 after edge t.
- Minimum transfer period is 3 cycles when the environment responds in zero cycles.
- A new capture is allowed on the edge after the return to IDLE. IDLE→REQ back-to-back with no gap cycle is not allowed, because a_i must be seen low first.
- If a_o is still 1 when REQ is entered, the FSM moves to RTZ on the next edge. This is legal and is not checked.
- In RTZ, the three release conditions may fall in any order or all together. The state waits for the last one.

## Configuration
- MUX_CHECK_EN defined:
  - err_o exists.
  - err_o is set, one cycle later, when ctl_i has two or more bits set in any cycle while in IDLE.
  - err_o is also set when ctl_i changes while in REQ.
  - err_o stays set until reset.
- MUX_CHECK_EN not defined: the err_o port and its logic are absent. Datapath and FSM behaviour are identical in both builds.

## Structure
- Package mux_pkg holds:
  - typedef enum mux_state_t {IDLE, REQ, RTZ}
  - function onehot_valid(vec) → bit
- Sub-module onehot_enc #(M) takes the M-bit vector and outputs valid (exactly one bit set) and idx[SW-1:0]. It is instantiated once on ctl_i.
- The data select is an indexed part-select of d_i using idx. No priority chain.

## Test plan
- Reset mid-transfer: N=8, M=4. Drive ctl_i=4'b0100, r_i[2]=1, d_i[2]=8'hA5. Hold a_o=0 and assert rst=0 while in REQ → all outputs 0 immediately. After release the FSM is in IDLE, and with r_i[2] still asserted it recaptures and re-issues d_o=8'hA5.
- Basic transfer: M=4, ctl_i=0100, r_i=0100, d_i[2]=8'h3C. r_o rises 1 cycle later with d_o=8'h3C. Pulse a_o → a_i=0100 and actl_o=1. Release all three → a_i=0 and actl_o=0.
- Non-selected request: r_i=1011, ctl_i=0010 → only channel 1 is acknowledged. Channels 0 and 3 see a_i=0 throughout.
- Invalid control: ctl_i=0110 with r_i[1]=r_i[2]=1 for 10 cycles → r_o stays 0. With MUX_CHECK_EN, err_o=1 from cycle 2 and stays set after ctl_i is corrected.
- Back-to-back: zero-delay consumer, alternating channels 0 and 3 for 16 transfers → each transfer takes exactly 3 cycles and the d_o sequence matches the inputs in order.
- Stall: hold a_o=0 for 20 cycles in REQ while toggling d_i[sel] and ctl_i → d_o stays constant and no a_i bit rises.
